// File: rtl/imm_ext_pkg.sv
// Shared mode codes and buffer-state encoding for the immediate extension pipe.
// No logic; referenced by imm_ext_core and imm_ext_pipe.
// Backpressure: not applicable.
package imm_ext_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_ZERO   = 3'd0;
    localparam mode_t MODE_SIGN   = 3'd1;
    localparam mode_t MODE_LUI    = 3'd2;
    localparam mode_t MODE_BRANCH = 3'd3;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender (ZERO/SIGN/LUI/BRANCH); IMM_EXT_ILLEGAL_TRAP_EN selects illegal-mode trapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller owns flow control.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm,
    input  mode_t            mode,
    output logic [OUT_W-1:0] value,
    output logic             err
);

    localparam int PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] sext;

    assign zext = {{PAD_W{1'b0}}, imm};
    assign sext = {{PAD_W{imm[IN_W-1]}}, imm};

    always_comb begin
        value = zext;
        err   = 1'b0;
        case (mode)
            MODE_ZERO:   value = zext;
            MODE_SIGN:   value = sext;
            MODE_LUI:    value = {imm, {PAD_W{1'b0}}};
            // Shift stays OUT_W wide, so the top two sign bits fall off.
            MODE_BRANCH: value = sext << 2;
            default: begin
`ifdef IMM_EXT_ILLEGAL_TRAP_EN
                value = '0;
                err   = 1'b1;
`else
                value = zext;
                err   = 1'b0;
`endif
            end
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Immediate extension stage with a 2-entry in-order output buffer; IMM_EXT_ILLEGAL_TRAP_EN enables out_err trapping.
// Latency: 1 cycle from acceptance into an empty buffer to out_valid.
// Backpressure: registered in_ready drops when both entries are occupied; output holds while out_ready is low.
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic             out_err
);

    generate
        if (OUT_W < IN_W + 2) begin : g_width_check
            $error("imm_ext_pipe: OUT_W must be at least IN_W+2");
        end
    endgenerate

    buf_state_t       state;
    logic [OUT_W-1:0] ent0_val;
    logic [OUT_W-1:0] ent1_val;
    logic             ent0_err;
    logic             ent1_err;
    logic [OUT_W-1:0] ext_val;
    logic             ext_err;
    logic             push;
    logic             pop;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm   (in_imm),
        .mode  (in_mode),
        .value (ext_val),
        .err   (ext_err)
    );

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Entry 0 is always the head and drives the outputs directly.
    assign out_imm = ent0_val;
    assign out_err = ent0_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            ent0_val  <= '0;
            ent1_val  <= '0;
            ent0_err  <= 1'b0;
            ent1_err  <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    in_ready <= 1'b1;
                    if (push) begin
                        ent0_val  <= ext_val;
                        ent0_err  <= ext_err;
                        state     <= ST_ONE;
                        out_valid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        ent0_val <= ext_val;
                        ent0_err <= ext_err;
                    end else if (push) begin
                        ent1_val <= ext_val;
                        ent1_err <= ext_err;
                        state    <= ST_FULL;
                        in_ready <= 1'b0;
                    end else if (pop) begin
                        state     <= ST_EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        ent0_val <= ent1_val;
                        ent0_err <= ent1_err;
                        state    <= ST_ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: arithmetic reference model, directed and random traffic.
// A second instance covers the narrow IN_W=12 / OUT_W=16 configuration.
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [2:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic        out_err;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [11:0] s_in_imm;
    logic [2:0]  s_in_mode;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [15:0] s_out_imm;
    logic        s_out_err;

    always #5 clk = ~clk;

    imm_ext_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_err   (out_err)
    );

    imm_ext_pipe #(.IN_W(12), .OUT_W(16)) dut_narrow (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_imm    (s_in_imm),
        .in_mode   (s_in_mode),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_imm   (s_out_imm),
        .out_err   (s_out_err)
    );

    typedef struct {
        logic [31:0] val;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   tp_active = 1'b0;
    bit   hold_pend = 1'b0;
    logic [31:0] hold_val;
    logic        hold_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: treat the immediate as a number, extend/scale it, reduce modulo 2^ow.
    function automatic longint unsigned ref_val(input longint unsigned imm, input int mode,
                                                input int iw, input int ow);
        longint unsigned span;
        longint          s;
        span = 64'd1 << ow;
        if (imm >= (64'd1 << (iw - 1)))
            s = $signed(imm) - $signed(64'd1 << iw);
        else
            s = $signed(imm);
        case (mode)
            0: return imm;
            1: return $unsigned(s) % span;
            2: return (imm * (64'd1 << (ow - iw))) % span;
            3: return $unsigned(s * 4) % span;
`ifdef IMM_EXT_ILLEGAL_TRAP_EN
            default: return 0;
`else
            default: return imm;
`endif
        endcase
    endfunction

    function automatic logic ref_err(input int mode);
`ifdef IMM_EXT_ILLEGAL_TRAP_EN
        return mode > 3;
`else
        return 1'b0;
`endif
    endfunction

    function automatic exp_t mk_exp(input logic [15:0] imm, input logic [2:0] mode);
        exp_t e;
        e.val = ref_val(imm, mode, 16, 32);
        e.err = ref_err(mode);
        return e;
    endfunction

    // Acceptance side: an edge with in_valid && in_ready is a transfer.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready)
            sb.push_back(mk_exp(in_imm, in_mode));
    end

    // Output side: compare every pop against the scoreboard head, and check stall stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend && out_valid) begin
                check("hold_imm", out_imm, hold_val);
                check("hold_err", out_err, hold_err);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_out: got 0x%0h with no pending entry at %0t", out_imm, $time);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_imm", out_imm, mon_e.val);
                    check("out_err", out_err, mon_e.err);
                end
            end
            hold_pend = out_valid && !out_ready;
            hold_val  = out_imm;
            hold_err  = out_err;
        end
    end

    always @(negedge clk) begin
        if (tp_active) begin
            check("tp_out_valid", out_valid, 1);
            check("tp_in_ready", in_ready, 1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    // Called at posedge+2; returns at posedge+2 just after the transfer edge with in_valid still high.
    task automatic send(input logic [15:0] imm, input logic [2:0] mode);
        int waits = 0;
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = mode;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck at 0 for imm 0x%0h", imm);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 100 && sb.size() > 0; i++)
            @(negedge clk);
        check("drain_sb_empty", sb.size(), 0);
        @(negedge clk);
        check("drain_out_valid", out_valid, 0);
        sync();
    endtask

    logic [31:0] mode_exp [4];
    logic [2:0]  sw_mode  [3];
    logic [15:0] sw_exp   [3];
    bit          acc;

    initial begin
        mode_exp = '{32'h0000_8004, 32'hFFFF_8004, 32'h8004_0000, 32'hFFFE_0010};
        sw_mode  = '{3'd1, 3'd3, 3'd2};
        sw_exp   = '{16'hF800, 16'hE000, 16'h8000};

        rst_n = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = '0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_imm = '0; s_in_mode = '0; s_out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_imm", out_imm, 0);
        check("rst_out_err", out_err, 0);
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_in_ready", in_ready, 0);
        @(negedge clk);
        check("first_edge_in_ready", in_ready, 1);

        out_ready = 1'b1;
        sync();
        for (int m = 0; m < 4; m++) begin
            send(16'h8004, 3'(m));
            in_valid = 1'b0;
            @(negedge clk);
            check($sformatf("mode%0d_valid", m), out_valid, 1);
            check($sformatf("mode%0d_imm", m), out_imm, mode_exp[m]);
            sync();
        end

        send(16'hFFFF, 3'd5);
        in_valid = 1'b0;
        @(negedge clk);
`ifdef IMM_EXT_ILLEGAL_TRAP_EN
        check("illegal_imm", out_imm, 32'h0);
        check("illegal_err", out_err, 1);
`else
        check("illegal_imm", out_imm, 32'h0000_FFFF);
        check("illegal_err", out_err, 0);
`endif
        sync();

        out_ready = 1'b0;
        send(16'h0001, 3'd1);
        send(16'h0002, 3'd1);
        in_imm = 16'h0003;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_imm", out_imm, 32'h1);
        end
        sync();
        out_ready = 1'b1;
        send(16'h0003, 3'd1);
        in_valid = 1'b0;
        drain();

        for (int i = 0; i < 8; i++) begin
            send(16'($urandom), 3'($urandom_range(0, 3)));
            if (i == 0) tp_active = 1'b1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        #1 tp_active = 1'b0;
        drain();

        acc = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_imm   = 16'($urandom);
                in_mode  = 3'($urandom_range(0, 7));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            sync();
        end
        in_valid = 1'b0;
        drain();

        out_ready = 1'b0;
        send(16'h1234, 3'd1);
        send(16'h5678, 3'd2);
        in_valid = 1'b0;
        @(negedge clk);
        check("full_in_ready", in_ready, 0);
        sync();
        rst_n = 1'b0;
        sync();
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_imm", out_imm, 0);
        check("midrst_in_ready", in_ready, 0);
        out_ready = 1'b1;
        @(negedge clk);
        check("midrst_in_ready_rise", in_ready, 1);
        check("midrst_no_stale", out_valid, 0);
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_stale", out_valid, 0);
        end
        sync();
        send(16'h00AB, 3'd0);
        in_valid = 1'b0;
        drain();

        for (int k = 0; k < 3; k++) begin
            s_in_valid = 1'b1;
            s_in_imm   = 12'h800;
            s_in_mode  = sw_mode[k];
            @(negedge clk);
            check("sweep_in_ready", s_in_ready, 1);
            sync();
            s_in_valid = 1'b0;
            @(negedge clk);
            check("sweep_valid", s_out_valid, 1);
            check($sformatf("sweep_mode%0d", sw_mode[k]), s_out_imm, sw_exp[k]);
            check("sweep_model", s_out_imm, ref_val(64'h800, int'(sw_mode[k]), 12, 16));
            sync();
        end

        check("final_sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
